// File: rtl/mantissa_align_pipe.sv
// mantissa_align_pipe: pipelined sticky right-alignment of the smaller FPU mantissa.
// Optional feature macro: ALIGN_SUBNORMAL_EN (explicit hidden-bit inputs for subnormals).
module mantissa_align_pipe #(
    parameter int MANTISSA_WIDTH = 23,
    parameter int SHIFT_WIDTH    = 5,
    parameter int PIPE_STAGES    = 2
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MANTISSA_WIDTH-1:0]   ma,
    input  logic [MANTISSA_WIDTH-1:0]   mb,
`ifdef ALIGN_SUBNORMAL_EN
    input  logic                        a_hidden,
    input  logic                        b_hidden,
`endif
    input  logic [SHIFT_WIDTH-1:0]      shift_spaces,
    input  logic [1:0]                  exp_disc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [MANTISSA_WIDTH+3:0]   mantissa_a_out,
    output logic [MANTISSA_WIDTH+3:0]   mantissa_b_out,
    output logic [1:0]                  exp_disc_out,
    output logic                        disc_err
);
    localparam int W  = MANTISSA_WIDTH + 4;
    localparam int CH = (SHIFT_WIDTH + PIPE_STAGES - 1) / PIPE_STAGES;

    // sw=1 means A is the operand being aligned; sh keeps the full amount, each stage masks its slice
    typedef struct packed {
        logic [W-1:0]           a;
        logic [W-1:0]           b;
        logic [SHIFT_WIDTH-1:0] sh;
        logic                   sw;
        logic [1:0]             disc;
        logic                   err;
    } stage_t;

    stage_t                 in_s;
    stage_t                 src [PIPE_STAGES];
    stage_t                 nxt [PIPE_STAGES];
    stage_t                 q   [PIPE_STAGES];
    logic [W-1:0]           shv [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] v_q;
    logic [PIPE_STAGES-1:0] vsrc;
    logic [PIPE_STAGES-1:0] ld;
    logic                   ha;
    logic                   hb;

    // Shift-amount bits owned by stage k; the last stage also takes every bit above its slice
    function automatic logic [SHIFT_WIDTH-1:0] chunk_mask(input int k);
        logic [SHIFT_WIDTH-1:0] m;
        for (int i = 0; i < SHIFT_WIDTH; i++)
            m[i] = (i >= k * CH) && (k == PIPE_STAGES - 1 || i < (k + 1) * CH);
        return m;
    endfunction

    // Right shift folding every dropped bit into bit 0; oversize shifts collapse to the sticky alone
    function automatic logic [W-1:0] sticky_shift(input logic [W-1:0] x, input logic [SHIFT_WIDTH-1:0] s);
        logic [W-1:0] r;
        logic [W-1:0] m;
        r = x >> s;
        m = ~({W{1'b1}} << s);
        r[0] = r[0] | (|(x & m));
        return r;
    endfunction

`ifdef ALIGN_SUBNORMAL_EN
    assign ha = a_hidden;
    assign hb = b_hidden;
`else
    assign ha = 1'b1;
    assign hb = 1'b1;
`endif

    // Build operands and canonicalise the exponent comparison for the incoming transaction
    always_comb begin
        in_s.a    = {ha, ma, 3'b000};
        in_s.b    = {hb, mb, 3'b000};
        in_s.sw   = exp_disc == 2'b00;
        in_s.sh   = exp_disc[0] ? '0 : shift_spaces;
        in_s.disc = {exp_disc[1] | exp_disc[0], exp_disc[0]};
        in_s.err  = exp_disc == 2'b01;
    end

    // Backpressure chain, stage sources and per-stage partial alignment
    always_comb begin
        ld = '0;
        ld[PIPE_STAGES-1] = !v_q[PIPE_STAGES-1] || out_ready;
        for (int k = PIPE_STAGES - 2; k >= 0; k--)
            ld[k] = !v_q[k] || ld[k+1];
        vsrc = '0;
        vsrc[0] = in_valid;
        src[0] = in_s;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            vsrc[k] = v_q[k-1];
            src[k]  = q[k-1];
        end
        for (int k = 0; k < PIPE_STAGES; k++) begin
            shv[k]   = sticky_shift(src[k].sw ? src[k].a : src[k].b, src[k].sh & chunk_mask(k));
            nxt[k]   = src[k];
            nxt[k].a = src[k].sw ? shv[k] : src[k].a;
            nxt[k].b = src[k].sw ? src[k].b : shv[k];
        end
    end

    // Stage registers advance only when the stage ahead frees up, so stalls hold data in place
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            v_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++)
                q[k] <= '0;
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++)
                if (ld[k]) begin
                    v_q[k] <= vsrc[k];
                    q[k]   <= nxt[k];
                end
        end
    end

    assign in_ready       = ld[0];
    assign out_valid      = v_q[PIPE_STAGES-1];
    assign mantissa_a_out = q[PIPE_STAGES-1].a;
    assign mantissa_b_out = q[PIPE_STAGES-1].b;
    assign exp_disc_out   = q[PIPE_STAGES-1].disc;
    assign disc_err       = q[PIPE_STAGES-1].err;
endmodule

// File: doc/mantissa_align_pipe.md
Name: mantissa_align_pipe

Overview:
Parametrised, pipelined successor to the single-cycle mantissa shifter in the FPU add/sub datapath.
- Takes two raw mantissas plus the exponent comparison result (exp_disc, shift amount) from the exponent-difference stage.
- Builds {hidden, mantissa, guard, round, sticky} operands and right-aligns the smaller one.
- Computes a true sticky bit and saturates oversize shifts.
- Moves data through PIPE_STAGES registered stages under a valid/ready handshake toward the significand adder.

Parameters:
MANTISSA_WIDTH, 23, stored mantissa bits (10 half, 23 single, 52 double)
SHIFT_WIDTH, 5, width of shift amount (6 for double)
PIPE_STAGES, 2, register stages, legal range 1..SHIFT_WIDTH; equals latency in cycles

Ports:
clk  in  1  clock, rising edge
arst_n  in  1  asynchronous active-low reset
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept input this cycle
ma  in  MANTISSA_WIDTH  mantissa A (no hidden bit)
mb  in  MANTISSA_WIDTH  mantissa B
shift_spaces  in  SHIFT_WIDTH  exponent difference
exp_disc  in  2  2'b10 A greater, 2'b00 B greater, 2'b11 equal, 2'b01 illegal
out_valid  out  1  output transaction valid
out_ready  in  1  downstream accepts output
mantissa_a_out  out  MANTISSA_WIDTH+4  aligned A {hidden, ma, G, R, S}
mantissa_b_out  out  MANTISSA_WIDTH+4  aligned B
exp_disc_out  out  2  exp_disc carried with the transaction (2'b01 replaced by 2'b11)
disc_err  out  1  transaction carried illegal exp_disc 2'b01

Behaviour:
- Reset (arst_n low, asynchronous): all stage valid bits 0, all data registers 0.
  - Therefore out_valid=0, mantissa_a_out=0, mantissa_b_out=0, exp_disc_out=0, disc_err=0.
  - in_ready=1 from the first cycle after reset release.
- Reset mid-operation: all in-flight transactions are dropped; no partial output is presented after release.
- Operand build: op = {1'b1, m, 3'b000}, width W = MANTISSA_WIDTH+4.
- Selection:
  - 2'b10: A passes unchanged; B is aligned by shift_spaces.
  - 2'b00: B passes unchanged; A is aligned.
  - 2'b11 or 2'b01: both pass unchanged and shift_spaces is ignored.
  - 2'b01 sets disc_err=1 for that transaction and exp_disc_out=2'b11.
- Alignment of operand x by s:
  - result = x >> s, then result[0] |= OR of all bits of x shifted out below bit 0.
  - If s >= W, result = {(W-1)'b0, 1'b1}, because the hidden bit is nonzero.
  - If s == 0, result = x.
- Pipelining:
  - Shift bits are distributed across stages, LSB-first, ceil(SHIFT_WIDTH/PIPE_STAGES) bits per stage; the last stage takes the remainder.
  - Sticky accumulates per stage; the final result must equal the single-step definition above for every PIPE_STAGES.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - Stage k loads when it is empty or stage k+1 loads (last stage: when out_ready); in_ready = stage 0 loads.
  - With out_ready held high: one transaction per cycle, latency exactly PIPE_STAGES cycles.
  - When out_valid && !out_ready, all outputs hold stable; upstream stages fill, then in_ready drops.
  - Simultaneous in and out transfers on a full pipeline are allowed, with no bubble.
  - Ordering preserved; no loss or duplication.
- Outputs are driven only from registers; no combinational path from in_valid/data to outputs. in_ready may depend combinationally on out_ready.

Optional Feature:
ALIGN_SUBNORMAL_EN
- Defined:
  - Adds input ports a_hidden and b_hidden (1 bit each, sampled with the transaction).
  - Operands are built as {a_hidden, ma, 3'b000} and {b_hidden, mb, 3'b000}.
  - Saturated shift of a zero operand gives all-zero with sticky 0.
- Undefined: ports absent; hidden bit is constant 1.

Test Plan:
- MW=23, PS=2, out_ready=1: ma=0, mb=23'h000007, exp_disc=2'b10, shift=6 → two cycles later mantissa_a_out=27'h4000000, mantissa_b_out=27'h0100001 (sticky set).
- exp_disc=2'b00, ma=23'h7FFFFF, shift=31 → mantissa_a_out=27'h0000001, mantissa_b_out={1,mb,000}.
- exp_disc=2'b11, shift=5 → both outputs unshifted, exp_disc_out=2'b11, disc_err=0. exp_disc=2'b01 → same data, disc_err=1.
- Back-to-back stream of 8 transactions with out_ready low for 3 cycles mid-stream:
  - in_ready drops once the pipeline is full.
  - Outputs are held stable while stalled.
  - All 8 results emerge in order with no duplicates; throughput returns to 1/cycle.
- Assert arst_n low with 2 transactions in flight → out_valid=0 and outputs zero immediately; after release, only new transactions appear.
- With ALIGN_SUBNORMAL_EN, b_hidden=0, mb=0, exp_disc=2'b10, shift=31 → mantissa_b_out=0 (sticky 0).
